// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: shared configuration for the retirement stage.
//   - datapath / index widths used on the commit_unit ports
//   - decoded instruction id constants
//   - store / conditional-branch / HALT classifiers
//   - flush/halt FSM state encoding (2 bits)
package commit_unit_pkg;

  localparam int InstrIdWidth = 6;
  localparam int RegIdxWidth  = 5;
  localparam int ROBIdxWidth  = 4;
  localparam int LSBIdxWidth  = 3;
  localparam int WordWidth    = 32;
  localparam int AddrWidth    = 32;

  typedef logic [InstrIdWidth-1:0] instr_id_t;

  localparam instr_id_t ID_NOP   = 6'd0;
  localparam instr_id_t ID_LUI   = 6'd1;
  localparam instr_id_t ID_AUIPC = 6'd2;
  localparam instr_id_t ID_JAL   = 6'd3;
  localparam instr_id_t ID_JALR  = 6'd4;
  localparam instr_id_t ID_BEQ   = 6'd5;
  localparam instr_id_t ID_BNE   = 6'd6;
  localparam instr_id_t ID_BLT   = 6'd7;
  localparam instr_id_t ID_BGE   = 6'd8;
  localparam instr_id_t ID_BLTU  = 6'd9;
  localparam instr_id_t ID_BGEU  = 6'd10;
  localparam instr_id_t ID_LB    = 6'd11;
  localparam instr_id_t ID_LH    = 6'd12;
  localparam instr_id_t ID_LW    = 6'd13;
  localparam instr_id_t ID_LBU   = 6'd14;
  localparam instr_id_t ID_LHU   = 6'd15;
  localparam instr_id_t ID_SB    = 6'd16;
  localparam instr_id_t ID_SH    = 6'd17;
  localparam instr_id_t ID_SW    = 6'd18;
  localparam instr_id_t ID_ADDI  = 6'd19;
  localparam instr_id_t ID_ADD   = 6'd28;
  localparam instr_id_t ID_SUB   = 6'd29;
  localparam instr_id_t ID_HALT  = 6'd63;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  function automatic logic is_store(input instr_id_t id);
    return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
  endfunction

  // Conditional branches only; JAL/JALR write rd and are not counted here.
  function automatic logic is_branch(input instr_id_t id);
    return (id >= ID_BEQ) && (id <= ID_BGEU);
  endfunction

  function automatic logic is_halt(input instr_id_t id);
    return id == ID_HALT;
  endfunction

endpackage

// File: rtl/commit_unit_flush_timer.sv
// commit_unit_flush_timer: holds the global branch clear for FLUSH_CYCLES
// enabled cycles after a load.
// Ports:
//   clk_in, rst_in  clock, synchronous active-high reset
//   en_in           global enable; low freezes the timer
//   load_in         start a flush window (sampled when en_in=1)
//   active_out      registered clear level
//   last_out        active and counter at zero: the window ends on the next enabled edge
module commit_unit_flush_timer #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  input  logic load_in,
  output logic active_out,
  output logic last_out
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(FLUSH_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          active_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (en_in) begin
      if (load_in) begin
        cnt_q    <= LOAD_VAL;
        active_q <= 1'b1;
      end else if (active_q) begin
        if (cnt_q == '0) begin
          active_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end

  assign active_out = active_q;
  assign last_out   = active_q && (cnt_q == '0);

endmodule

// File: rtl/commit_unit.sv
// commit_unit: retirement stage downstream of the reorder buffer.
// Retires one instruction per commit pulse: register write + rename tag
// release, store release to the LSB, redirect with global branch clear,
// and HALT. Owns the RUN/FLUSH/HALTED FSM and the retired counter.
// Inputs:  clk_in, rst_in (sync, active-high), rdy_in (global enable),
//          commit_en_in, instr_id_in, rd_in, rob_pos_in, lsb_pos_in,
//          res_in, jump_en_in, jump_a_in
// Outputs: reg_wr_{en,rd,data,rob_pos}_out, lsb_commit_{en,pos}_out,
//          clear_branch_out, pc_redirect_{en,a}_out, halt_out,
//          retired_cnt_out
// Optional: define COMMIT_PERF_EN to add mispredict_cnt_out and
//           store_cnt_out.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   commit_en_in,
  input  logic [InstrIdWidth-1:0] instr_id_in,
  input  logic [RegIdxWidth-1:0]  rd_in,
  input  logic [ROBIdxWidth-1:0]  rob_pos_in,
  input  logic [LSBIdxWidth-1:0]  lsb_pos_in,
  input  logic [WordWidth-1:0]    res_in,
  input  logic                    jump_en_in,
  input  logic [AddrWidth-1:0]    jump_a_in,
  output logic                    reg_wr_en_out,
  output logic [RegIdxWidth-1:0]  reg_wr_rd_out,
  output logic [WordWidth-1:0]    reg_wr_data_out,
  output logic [ROBIdxWidth-1:0]  reg_wr_rob_pos_out,
  output logic                    lsb_commit_en_out,
  output logic [LSBIdxWidth-1:0]  lsb_commit_pos_out,
  output logic                    clear_branch_out,
  output logic                    pc_redirect_en_out,
  output logic [AddrWidth-1:0]    pc_redirect_a_out,
  output logic                    halt_out,
`ifdef COMMIT_PERF_EN
  output logic [CNT_WIDTH-1:0]    mispredict_cnt_out,
  output logic [CNT_WIDTH-1:0]    store_cnt_out,
`endif
  output logic [CNT_WIDTH-1:0]    retired_cnt_out
);

  state_e                  state_q;
  logic                    reg_wr_en_q;
  logic [RegIdxWidth-1:0]  reg_wr_rd_q;
  logic [WordWidth-1:0]    reg_wr_data_q;
  logic [ROBIdxWidth-1:0]  reg_wr_rob_pos_q;
  logic                    lsb_commit_en_q;
  logic [LSBIdxWidth-1:0]  lsb_commit_pos_q;
  logic                    pc_redirect_en_q;
  logic [AddrWidth-1:0]    pc_redirect_a_q;
  logic                    halt_q;
  logic [CNT_WIDTH-1:0]    retired_cnt_q;
`ifdef COMMIT_PERF_EN
  logic [CNT_WIDTH-1:0]    mispredict_cnt_q;
  logic [CNT_WIDTH-1:0]    store_cnt_q;
`endif

  logic retire;
  logic do_halt;
  logic do_store;
  logic do_redirect;
  logic do_reg_wr;
  logic flush_active;
  logic flush_last;

  // Decode of the commit being retired this edge; only meaningful in RUN.
  always_comb begin
    retire      = (state_q == ST_RUN) && commit_en_in;
    do_halt     = retire && is_halt(instr_id_in);
    do_store    = retire && !do_halt && is_store(instr_id_in);
    do_redirect = retire && !do_halt && jump_en_in;
    do_reg_wr   = retire && !do_halt && !is_store(instr_id_in) &&
                  !is_branch(instr_id_in) && (rd_in != '0);
  end

  commit_unit_flush_timer #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_in      (rdy_in),
    .load_in    (do_redirect),
    .active_out (flush_active),
    .last_out   (flush_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q            <= ST_RUN;
      reg_wr_en_q        <= 1'b0;
      reg_wr_rd_q        <= '0;
      reg_wr_data_q      <= '0;
      reg_wr_rob_pos_q   <= '0;
      lsb_commit_en_q    <= 1'b0;
      lsb_commit_pos_q   <= '0;
      pc_redirect_en_q   <= 1'b0;
      pc_redirect_a_q    <= '0;
      halt_q             <= 1'b0;
      retired_cnt_q      <= '0;
`ifdef COMMIT_PERF_EN
      mispredict_cnt_q   <= '0;
      store_cnt_q        <= '0;
`endif
    end else if (rdy_in) begin
      reg_wr_en_q      <= 1'b0;
      lsb_commit_en_q  <= 1'b0;
      pc_redirect_en_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (retire) begin
            retired_cnt_q <= retired_cnt_q + CNT_WIDTH'(1);
          end
          if (do_reg_wr) begin
            reg_wr_en_q      <= 1'b1;
            reg_wr_rd_q      <= rd_in;
            reg_wr_data_q    <= res_in;
            reg_wr_rob_pos_q <= rob_pos_in;
          end
          if (do_store) begin
            lsb_commit_en_q  <= 1'b1;
            lsb_commit_pos_q <= lsb_pos_in;
`ifdef COMMIT_PERF_EN
            store_cnt_q      <= store_cnt_q + CNT_WIDTH'(1);
`endif
          end
          if (do_halt) begin
            halt_q  <= 1'b1;
            state_q <= ST_HALTED;
          end else if (do_redirect) begin
            pc_redirect_en_q <= 1'b1;
            pc_redirect_a_q  <= jump_a_in;
            state_q          <= ST_FLUSH;
`ifdef COMMIT_PERF_EN
            mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
`endif
          end
        end
        ST_FLUSH: begin
          // The timer drops the clear on this same edge.
          if (flush_last) begin
            state_q <= ST_RUN;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign reg_wr_en_out      = reg_wr_en_q;
  assign reg_wr_rd_out      = reg_wr_rd_q;
  assign reg_wr_data_out    = reg_wr_data_q;
  assign reg_wr_rob_pos_out = reg_wr_rob_pos_q;
  assign lsb_commit_en_out  = lsb_commit_en_q;
  assign lsb_commit_pos_out = lsb_commit_pos_q;
  assign clear_branch_out   = flush_active;
  assign pc_redirect_en_out = pc_redirect_en_q;
  assign pc_redirect_a_out  = pc_redirect_a_q;
  assign halt_out           = halt_q;
  assign retired_cnt_out    = retired_cnt_q;
`ifdef COMMIT_PERF_EN
  assign mispredict_cnt_out = mispredict_cnt_q;
  assign store_cnt_out      = store_cnt_q;
`endif

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Retirement stage directly downstream of the reorder buffer.
- Consumes the one-cycle commit pulse and retires the instruction:
  - writes the architectural register file and releases its rename tag;
  - releases committed stores in the load/store buffer;
  - on a redirect, drives the global branch clear and the new PC to fetch;
  - stops the core on HALT.
- Owns the flush/halt FSM and the retired-instruction counter.

Parameters:
- FLUSH_CYCLES, 1: cycles clear_branch_out stays high per redirect (≥1).
- CNT_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset.
- rdy_in  in  1  global enable; low freezes all state.
- commit_en_in  in  1  commit pulse from ROB.
- instr_id_in  in  `InstrIdWidth  decoded instruction id.
- rd_in  in  `RegIdxWidth  destination register.
- rob_pos_in  in  `ROBIdxWidth  ROB slot being retired.
- lsb_pos_in  in  `LSBIdxWidth  LSB slot (stores).
- res_in  in  `WordWidth  result value.
- jump_en_in  in  1  redirect required.
- jump_a_in  in  `AddrWidth  redirect target.
- reg_wr_en_out  out  1  register file write strobe.
- reg_wr_rd_out  out  `RegIdxWidth  write index.
- reg_wr_data_out  out  `WordWidth  write data.
- reg_wr_rob_pos_out  out  `ROBIdxWidth  tag; the regfile clears its rename only if it matches.
- lsb_commit_en_out  out  1  store release strobe.
- lsb_commit_pos_out  out  `LSBIdxWidth  store slot.
- clear_branch_out  out  1  global flush.
- pc_redirect_en_out  out  1  fetch redirect strobe.
- pc_redirect_a_out  out  `AddrWidth  new PC.
- halt_out  out  1  core halted (sticky).
- retired_cnt_out  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- One clock, clk_in; reset rst_in is synchronous, active-high.
- Reset values:
  - every output 0;
  - FSM = RUN;
  - flush counter 0.
- Sampling rules:
  - All outputs are registered.
  - Inputs are sampled only on edges where rdy_in=1 and rst_in=0.
  - When rdy_in=0, all state and outputs hold. The ROB holds its pulse under rdy_in=0, so no double retirement occurs.
- Strobes (reg_wr_en_out, lsb_commit_en_out, pc_redirect_en_out) are 1-cycle pulses. Each is driven by default to 0 on every rdy edge.
- FSM RUN, input commit_en_in=1:
  - Increment retired_cnt_out; it wraps at 2^CNT_WIDTH.
  - Register write: if instr_id_in is not a store, branch or HALT, and rd_in≠0, pulse reg_wr_en_out with rd_in, res_in and rob_pos_in. rd_in=0 never writes.
  - Store: if instr_id_in is a store (SB/SH/SW), pulse lsb_commit_en_out with lsb_pos_in.
  - Redirect: if jump_en_in=1, pulse pc_redirect_en_out with pc_redirect_a_out=jump_a_in. Also set clear_branch_out=1, load flush counter with FLUSH_CYCLES-1, and go to FLUSH.
  - Register write and redirect in the same commit (JAL/JALR): both fire in the same cycle.
  - HALT: go to HALTED and set halt_out=1. HALT has no jump_en_in.
- FSM RUN, commit_en_in=0: no action.
- FSM FLUSH:
  - commit_en_in is ignored; the ROB is being cleared, so nothing is retired and nothing is counted.
  - clear_branch_out stays high while the counter is >0; the counter decrements each rdy edge.
  - When the counter reaches 0, clear_branch_out drops and the FSM returns to RUN.
  - Total high time is exactly FLUSH_CYCLES rdy-cycles.
- FSM HALTED:
  - Terminal until reset.
  - All commits are ignored, and no strobes fire.
- Reset mid-FLUSH or mid-HALTED: return to RUN with all outputs 0 on the next edge.
- Latency: a commit sampled on edge N appears on outputs after edge N.

Optional Feature:
- Macro COMMIT_PERF_EN.
- When defined, two extra outputs of CNT_WIDTH are added:
  - mispredict_cnt_out: increments on each redirect.
  - store_cnt_out: increments on each store release.
  - Both reset to 0, hold when rdy_in=0, and wrap.
- When undefined, neither the ports nor the registers exist.

Decomposition:
- Shared config include (alongside the existing width macros) holds:
  - instruction id constants;
  - is_store / is_branch / HALT id classifier macros;
  - FSM state encodings RUN/FLUSH/HALTED (2 bits).
- Sub-module flush_timer: counter with load/decrement/zero-detect driving clear_branch_out.

Test Plan:
- ADDI, rd=5, res=0x1234, rob_pos=3 → next cycle:
  - reg_wr_en_out=1 with rd=5, data=0x1234, tag=3;
  - retired_cnt_out=1.
- ADD with rd=0 → reg_wr_en_out stays 0; retired_cnt_out increments.
- SW, lsb_pos=2 → lsb_commit_en_out=1 with pos=2, reg_wr_en_out=0.
- JALR, rd=1, res=0x104, jump_en=1, jump_a=0x200, FLUSH_CYCLES=3:
  - reg write and pc redirect to 0x200 in the same cycle;
  - clear_branch_out high exactly 3 cycles;
  - a commit pulse during those cycles produces no strobe and no count.
- HALT commit → halt_out=1 sticky. Later commits produce no strobes.
- Reset mid-FLUSH → clear_branch_out=0 next cycle, FSM RUN, retired_cnt_out=0.
